// File: rtl/riscv_pkg.sv
// Shared definitions for the single-cycle RISC-V core. Holds the opcode map (also
// decoded by control_block), the NOP encoding, fault cause codes and the fetch FSM
// state encoding, plus a few small helpers used by the fetch unit.
package riscv_pkg;

  // RV32I base opcodes (instr[6:0])
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // addi x0, x0, 0 -- presented on instr while nothing has been fetched yet
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Width of a PC / instruction word and PC step
  localparam int unsigned XLEN     = 32;
  localparam logic [31:0] PC_STEP  = 32'd4;

  // Why the fetch unit halted the core
  typedef enum logic [1:0] {
    FC_NONE       = 2'b00,
    FC_MISALIGNED = 2'b01,
    FC_TIMEOUT    = 2'b10
  } fault_cause_e;

  // Fetch FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FETCH = 2'b01,
    ST_EXEC  = 2'b10,
    ST_HALT  = 2'b11
  } fetch_state_e;

  // Next PC selection. The target path clears bit 0 so JALR needs no extra masking
  // in the ALU; branch and JAL targets already have bit 0 clear.
  function automatic logic [31:0] calc_next_pc(
    input logic        sel,
    input logic [31:0] target,
    input logic [31:0] seq_pc
  );
    return sel ? (target & 32'hFFFF_FFFE) : seq_pc;
  endfunction

  // Instruction fetches must be word aligned; bit 0 is always clear after
  // calc_next_pc so only bit 1 can flag a bad address.
  function automatic logic pc_misaligned(input logic [31:0] addr);
    return addr[1];
  endfunction

  // Field extractors shared with control_block
  function automatic logic [6:0] get_opcode(input logic [31:0] word);
    return word[6:0];
  endfunction

  function automatic logic [2:0] get_func3(input logic [31:0] word);
    return word[14:12];
  endfunction

  function automatic logic [6:0] get_func7(input logic [31:0] word);
    return word[31:25];
  endfunction

endpackage

// File: rtl/ifu_watchdog.sv
// Fetch watchdog: counts consecutive cycles spent waiting for an instruction memory
// acknowledge and flags expiry on the cycle the limit is reached. A limit of zero
// disables the watchdog entirely.
module ifu_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,   // hold the count at zero (not waiting on memory)
  input  logic i_enable,  // one more cycle without acknowledge
  output logic o_expired  // limit reached this cycle
);

  // Count only needs to reach TIMEOUT_CYCLES-1 before expiry ends the wait
  localparam int unsigned CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT_M1 =
    CW'((TIMEOUT_CYCLES == 0) ? 0 : (TIMEOUT_CYCLES - 1));
  localparam logic ENABLED = (TIMEOUT_CYCLES != 0);

  logic [CW-1:0] r_count;

  // Count waiting cycles; cleared whenever the fetch unit is not waiting
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_count <= '0;
    end else if (ENABLED && i_enable) begin
      r_count <= r_count + 1'b1;
    end
  end

  // The current cycle is the TIMEOUT_CYCLES-th wait cycle when the count already
  // holds TIMEOUT_CYCLES-1; an acknowledge this cycle drops i_enable and wins.
  assign o_expired = ENABLED && i_enable && (r_count == LIMIT_M1);

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit for the single-cycle core. Owns the PC, fetches one word
// per instruction over a req/ack handshake, holds it stable while the datapath
// executes, and picks the next PC from pc_sel/pc_target. Halts on a misaligned
// next PC or a fetch that never gets acknowledged. RESET_PC must be word aligned.
module instr_fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  // instruction memory
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  // from control_block / ALU
  input  logic        pc_sel,
  input  logic [31:0] pc_target,
  input  logic        exec_done,
  // to control_block / datapath
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [6:0]  opcode,
  output logic [2:0]  func3,
  output logic [6:0]  func7,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  // status
  output logic        fault,
  output logic [1:0]  fault_cause,
  output logic [63:0] instret
);

  fetch_state_e r_state;
  fetch_state_e w_state_next;

  logic [31:0]  r_pc;
  logic [31:0]  r_instr;
  logic         r_fault;
  fault_cause_e r_fault_cause;
  logic [63:0]  r_instret;

  logic [31:0]  w_pc_plus4;
  logic [31:0]  w_next_pc;
  logic         w_misaligned;
  logic         w_fetch_ack;
  logic         w_retire;
  logic         w_wd_clear;
  logic         w_wd_enable;
  logic         w_wd_expired;

  // ---------------------------------------------------------------------------
  // Next-PC datapath
  // ---------------------------------------------------------------------------
  assign w_pc_plus4   = r_pc + PC_STEP;
  assign w_next_pc    = calc_next_pc(pc_sel, pc_target, w_pc_plus4);
  assign w_misaligned = pc_misaligned(w_next_pc);

  // Handshake qualifiers: ack only counts in FETCH, exec_done only in EXEC
  assign w_fetch_ack = (r_state == ST_FETCH) && imem_ack;
  assign w_retire    = (r_state == ST_EXEC) && exec_done;

  // Watchdog runs only while a request is outstanding
  assign w_wd_clear  = (r_state != ST_FETCH);
  assign w_wd_enable = (r_state == ST_FETCH) && !imem_ack;

  ifu_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (w_wd_clear),
    .i_enable  (w_wd_enable),
    .o_expired (w_wd_expired)
  );

  // ---------------------------------------------------------------------------
  // Fetch FSM
  // ---------------------------------------------------------------------------

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: ack beats a simultaneous watchdog expiry because expiry is
  // only raised when no ack is present.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        w_state_next = ST_FETCH;
      end
      ST_FETCH: begin
        if (imem_ack) begin
          w_state_next = ST_EXEC;
        end else if (w_wd_expired) begin
          w_state_next = ST_HALT;
        end
      end
      ST_EXEC: begin
        if (exec_done) begin
          w_state_next = w_misaligned ? ST_HALT : ST_FETCH;
        end
      end
      ST_HALT: begin
        w_state_next = ST_HALT;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Output logic: rst drops the request combinationally so memory abandons any
  // pending access in the reset cycle itself, and no instruction is offered.
  always_comb begin
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    if (!rst) begin
      case (r_state)
        ST_FETCH: imem_req    = 1'b1;
        ST_EXEC:  instr_valid = 1'b1;
        default: begin
          imem_req    = 1'b0;
          instr_valid = 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Architectural registers
  // ---------------------------------------------------------------------------

  // PC advances on retire; a misaligned target leaves PC on the faulting instruction
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= RESET_PC;
    end else if (w_retire && !w_misaligned) begin
      r_pc <= w_next_pc;
    end
  end

  // Instruction word captured on the accepted ack and held through EXEC
  always_ff @(posedge clk) begin
    if (rst) begin
      r_instr <= NOP_INSTR;
    end else if (w_fetch_ack) begin
      r_instr <= imem_rdata;
    end
  end

  // Retired-instruction counter; the instruction's write-back commits on exec_done
  // even when its next PC turns out misaligned, so it counts as retired.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_instret <= 64'd0;
    end else if (w_retire) begin
      r_instret <= r_instret + 64'd1;
    end
  end

  // Sticky fault flag; only the first cause is recorded
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fault       <= 1'b0;
      r_fault_cause <= FC_NONE;
    end else if (!r_fault) begin
      if (w_retire && w_misaligned) begin
        r_fault       <= 1'b1;
        r_fault_cause <= FC_MISALIGNED;
      end else if (w_wd_expired) begin
        r_fault       <= 1'b1;
        r_fault_cause <= FC_TIMEOUT;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output mapping
  // ---------------------------------------------------------------------------
  assign imem_addr   = r_pc;
  assign instr       = r_instr;
  assign opcode      = get_opcode(r_instr);
  assign func3       = get_func3(r_instr);
  assign func7       = get_func7(r_instr);
  assign pc          = r_pc;
  assign pc_plus4    = w_pc_plus4;
  assign fault       = r_fault;
  assign fault_cause = r_fault_cause;
  assign instret     = r_instret;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: a table of instructions walked through
// fetch/execute with an expected-result queue, plus hand-written reset and
// watchdog sequences.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        pc_sel;
  logic [31:0] pc_target;
  logic        exec_done;
  logic        instr_valid;
  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [2:0]  func3;
  logic [6:0]  func7;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fault;
  logic [1:0]  fault_cause;
  logic [63:0] instret;

  int n_checks = 0;
  int n_pass   = 0;

  instr_fetch_unit #(
    .RESET_PC       (32'h0000_0000),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .pc_sel      (pc_sel),
    .pc_target   (pc_target),
    .exec_done   (exec_done),
    .instr_valid (instr_valid),
    .instr       (instr),
    .opcode      (opcode),
    .func3       (func3),
    .func7       (func7),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .fault       (fault),
    .fault_cause (fault_cause),
    .instret     (instret)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          ack_delay;  // FETCH cycles without ack before the ack
    int          exec_wait;  // EXEC cycles before exec_done
    logic [31:0] rdata;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] exp_pc;     // address this instruction must be fetched from
    logic        sel;
    logic [31:0] target;
    logic        exp_fault;
  } vec_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
  } exp_t;

  vec_t vecs[8];
  exp_t sb[$];
  exp_t e;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " imem_req"},    {63'd0, imem_req},    64'd0);
    chk({tag, " instr_valid"}, {63'd0, instr_valid}, 64'd0);
    chk({tag, " pc"},          {32'd0, pc},          64'h0);
    chk({tag, " instr"},       {32'd0, instr},       64'h13);
    chk({tag, " fault"},       {63'd0, fault},       64'd0);
    chk({tag, " fault_cause"}, {62'd0, fault_cause}, 64'd0);
    chk({tag, " instret"},     instret,              64'd0);
  endtask

  // Reset for two edges, release, and land in the first FETCH cycle
  task automatic do_reset();
    rst = 1'b1; imem_ack = 1'b0; exec_done = 1'b0; pc_sel = 1'b0;
    step(); step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL sim_timeout: got no finish expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    //           dly wt rdata          opc    f3    f7     exp_pc         sel   target         flt
    vecs[0] = '{0, 0, 32'h0050_0093, 7'h13, 3'd0, 7'h00, 32'h0000_0000, 1'b0, 32'h0,         1'b0};
    vecs[1] = '{3, 0, 32'h4020_8133, 7'h33, 3'd0, 7'h20, 32'h0000_0004, 1'b1, 32'h0000_0040, 1'b0};
    vecs[2] = '{1, 0, 32'h0000_006F, 7'h6F, 3'd0, 7'h00, 32'h0000_0040, 1'b1, 32'h0000_0100, 1'b0};
    vecs[3] = '{2, 1, 32'hFE20_CEE3, 7'h63, 3'd4, 7'h7F, 32'h0000_0100, 1'b1, 32'h0000_0205, 1'b0};
    vecs[4] = '{0, 2, 32'h1234_5678, 7'h78, 3'd5, 7'h09, 32'h0000_0204, 1'b0, 32'h0000_0300, 1'b0};
    vecs[5] = '{3, 0, 32'hFFFF_FFFF, 7'h7F, 3'd7, 7'h7F, 32'h0000_0208, 1'b1, 32'hFFFF_FFFC, 1'b0};
    vecs[6] = '{0, 0, 32'h0000_0013, 7'h13, 3'd0, 7'h00, 32'hFFFF_FFFC, 1'b0, 32'h0,         1'b0};
    vecs[7] = '{0, 0, 32'h00A0_0513, 7'h13, 3'd0, 7'h00, 32'h0000_0000, 1'b1, 32'h0000_0102, 1'b1};

    rst = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0; exec_done = 1'b0;
    pc_sel = 1'b0; pc_target = 32'h0;
    step(); step();
    chk_reset_vals("reset");
    rst = 1'b0;
    step();

    // Table-driven fetch/execute
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("v%0d req", i),  {63'd0, imem_req}, 64'd1);
      chk($sformatf("v%0d addr", i), {32'd0, imem_addr}, {32'd0, vecs[i].exp_pc});
      for (int d = 0; d < vecs[i].ack_delay; d++) begin
        // exec_done/pc_sel outside EXEC must be ignored
        exec_done = 1'b1; pc_sel = 1'b1; pc_target = 32'hDEAD_BEE0;
        step();
        exec_done = 1'b0; pc_sel = 1'b0;
        chk($sformatf("v%0d wait req", i),   {63'd0, imem_req}, 64'd1);
        chk($sformatf("v%0d wait addr", i),  {32'd0, imem_addr}, {32'd0, vecs[i].exp_pc});
        chk($sformatf("v%0d wait valid", i), {63'd0, instr_valid}, 64'd0);
      end
      imem_ack = 1'b1; imem_rdata = vecs[i].rdata;
      sb.push_back('{vecs[i].exp_pc, vecs[i].rdata, vecs[i].opc, vecs[i].f3, vecs[i].f7});
      step();
      imem_ack = 1'b0;
      chk($sformatf("v%0d valid", i), {63'd0, instr_valid}, 64'd1);
      chk($sformatf("v%0d req off", i), {63'd0, imem_req}, 64'd0);
      if (sb.size() == 0) begin
        chk($sformatf("v%0d sb empty", i), 64'd0, 64'd1);
      end else begin
        e = sb.pop_front();
        chk($sformatf("v%0d instr", i),    {32'd0, instr},    {32'd0, e.word});
        chk($sformatf("v%0d opcode", i),   {57'd0, opcode},   {57'd0, e.opc});
        chk($sformatf("v%0d func3", i),    {61'd0, func3},    {61'd0, e.f3});
        chk($sformatf("v%0d func7", i),    {57'd0, func7},    {57'd0, e.f7});
        chk($sformatf("v%0d pc", i),       {32'd0, pc},       {32'd0, e.pc});
        chk($sformatf("v%0d pc_plus4", i), {32'd0, pc_plus4}, {32'd0, e.pc + 32'd4});
      end
      for (int w = 0; w < vecs[i].exec_wait; w++) begin
        // a stray ack during EXEC must not disturb the held word
        imem_ack = 1'b1; imem_rdata = ~vecs[i].rdata;
        step();
        imem_ack = 1'b0;
        chk($sformatf("v%0d hold instr", i), {32'd0, instr}, {32'd0, vecs[i].rdata});
        chk($sformatf("v%0d hold valid", i), {63'd0, instr_valid}, 64'd1);
      end
      exec_done = 1'b1; pc_sel = vecs[i].sel; pc_target = vecs[i].target;
      step();
      exec_done = 1'b0; pc_sel = 1'b0;
      $display("txn %0d: pc=%08h instr=%08h sel=%0d target=%08h -> next addr=%08h instret=%0d fault=%0d",
               i, vecs[i].exp_pc, vecs[i].rdata, vecs[i].sel, vecs[i].target, imem_addr, instret, fault);
      if (vecs[i].exp_fault) begin
        chk($sformatf("v%0d fault", i),       {63'd0, fault},       64'd1);
        chk($sformatf("v%0d fault_cause", i), {62'd0, fault_cause}, 64'd1);
        chk($sformatf("v%0d halt req", i),    {63'd0, imem_req},    64'd0);
        chk($sformatf("v%0d halt valid", i),  {63'd0, instr_valid}, 64'd0);
        chk($sformatf("v%0d halt pc", i),     {32'd0, pc},          {32'd0, vecs[i].exp_pc});
      end else begin
        chk($sformatf("v%0d instret", i), instret, 64'(i + 1));
        chk($sformatf("v%0d no fault", i), {63'd0, fault}, 64'd0);
      end
    end

    // HALT is permanent: acks and exec_done do nothing
    for (int k = 0; k < 4; k++) begin
      imem_ack = 1'b1; exec_done = 1'b1; pc_sel = 1'b1; pc_target = 32'h0000_0200;
      step();
      chk("halt hold req",   {63'd0, imem_req},    64'd0);
      chk("halt hold pc",    {32'd0, pc},          64'h0);
      chk("halt hold cause", {62'd0, fault_cause}, 64'd1);
    end
    imem_ack = 1'b0; exec_done = 1'b0; pc_sel = 1'b0;

    // Reset mid-EXEC: one retire, then reset while exec_done is asserted
    do_reset();
    imem_ack = 1'b1; imem_rdata = 32'h0000_0013;
    step();
    imem_ack = 1'b0;
    exec_done = 1'b1;
    step();
    exec_done = 1'b0;
    chk("pre-rst instret", instret, 64'd1);
    chk("pre-rst addr", {32'd0, imem_addr}, 64'h4);
    imem_ack = 1'b1; imem_rdata = 32'h0000_006F;
    step();
    imem_ack = 1'b0;
    chk("pre-rst exec valid", {63'd0, instr_valid}, 64'd1);
    rst = 1'b1; exec_done = 1'b1; pc_sel = 1'b1; pc_target = 32'h0000_0080;
    #1;
    chk("rst exec valid drop", {63'd0, instr_valid}, 64'd0);
    step();
    exec_done = 1'b0; pc_sel = 1'b0;
    chk_reset_vals("rst-exec");
    rst = 1'b0;
    step();
    chk("rst-exec refetch req",  {63'd0, imem_req}, 64'd1);
    chk("rst-exec refetch addr", {32'd0, imem_addr}, 64'h0);

    // Reset mid-FETCH: request must drop in the reset cycle itself
    step();
    chk("mid-fetch req", {63'd0, imem_req}, 64'd1);
    rst = 1'b1;
    #1;
    chk("rst fetch req drop", {63'd0, imem_req}, 64'd0);
    imem_ack = 1'b1; imem_rdata = 32'hFFFF_FFFF;
    step();
    imem_ack = 1'b0;
    chk_reset_vals("rst-fetch");
    rst = 1'b0;
    step();
    chk("rst-fetch refetch req",  {63'd0, imem_req}, 64'd1);
    chk("rst-fetch refetch addr", {32'd0, imem_addr}, 64'h0);

    // Watchdog: no ack for 4 FETCH cycles -> timeout fault
    for (int c = 2; c <= 4; c++) begin
      step();
      chk($sformatf("wd cycle%0d req", c),   {63'd0, imem_req}, 64'd1);
      chk($sformatf("wd cycle%0d fault", c), {63'd0, fault},    64'd0);
    end
    step();
    chk("wd fault",       {63'd0, fault},       64'd1);
    chk("wd fault_cause", {62'd0, fault_cause}, 64'd2);
    chk("wd halt req",    {63'd0, imem_req},    64'd0);
    step();
    chk("wd halt stays",  {63'd0, imem_req},    64'd0);

    // Watchdog: ack on the 4th FETCH cycle wins
    do_reset();
    step(); step(); step();
    chk("wd4 req", {63'd0, imem_req}, 64'd1);
    imem_ack = 1'b1; imem_rdata = 32'h0040_0093;
    step();
    imem_ack = 1'b0;
    chk("wd4 no fault", {63'd0, fault},       64'd0);
    chk("wd4 cause",    {62'd0, fault_cause}, 64'd0);
    chk("wd4 valid",    {63'd0, instr_valid}, 64'd1);
    chk("wd4 instr",    {32'd0, instr},       64'h0040_0093);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
